// File: rtl/bram_pkg.sv
// Shared defaults and state encoding for the display-BRAM sequencing logic.
package bram_pkg;

  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned SCAN_DIV_DEF = 50_000_000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StWrite = S_WRITE,
    StClear = S_CLEAR
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV enabled cycles, holds while en is low.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bram_seq_ctrl.sv
// Arbitrates the single BRAM port between manual write, manual step, auto-scan and full clear.
module bram_seq_ctrl
  import bram_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEF,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_btn,
  input  logic              wr_btn,
  input  logic              clr_req,
  input  logic              scan_en,
  input  logic [DATA_W-1:0] data_sw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              mem_we_d, busy_d;
  logic              inc_q, wr_q;
  logic              inc_pending_q, inc_pending_d;
  logic              clr_pending_q, clr_pending_d;
  logic              inc_edge, wr_edge;
  logic              scan_tick, scan_rst, scan_run;
  logic [ADDR_W-1:0] disp_pipe_q [RD_LAT];

  assign inc_edge = inc_btn & ~inc_q;
  assign wr_edge  = wr_btn & ~wr_q;

  // Prescaler restarts whenever scanning is off and freezes outside IDLE.
  assign scan_rst = rst | ~scan_en;
  assign scan_run = scan_en & (state_q == StIdle);

  tick_gen #(
    .DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (scan_rst),
    .en   (scan_run),
    .tick (scan_tick)
  );

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    clr_cnt_d     = clr_cnt_q;
    mem_wdata_d   = mem_wdata;
    busy_d        = busy;
    inc_pending_d = inc_pending_q;
    clr_pending_d = clr_pending_q | clr_req;

    unique case (state_q)
      StIdle: begin
        if (clr_pending_q) begin
          state_d       = StClear;
          clr_pending_d = 1'b0;
          clr_cnt_d     = '0;
          busy_d        = 1'b1;
        end else if (wr_edge) begin
          state_d     = StWrite;
          mem_wdata_d = data_sw;
          if (inc_edge) begin
            inc_pending_d = 1'b1;
          end
        end else if (inc_edge || inc_pending_q || scan_tick) begin
          cur_addr_d    = cur_addr_q + ADDR_W'(1);
          inc_pending_d = 1'b0;
        end
      end
      StWrite: begin
        state_d = StIdle;
        if (inc_edge) begin
          inc_pending_d = 1'b1;
        end
      end
      StClear: begin
        clr_pending_d = clr_pending_q;
        inc_pending_d = 1'b0;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d    = StIdle;
          cur_addr_d = '0;
          busy_d     = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered against the next state so they line up with it.
    if (state_d == StClear) begin
      mem_wdata_d = '0;
    end
    mem_we_d   = (state_d != StIdle);
    mem_addr_d = (state_d == StClear) ? clr_cnt_d : cur_addr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cur_addr_q    <= '0;
      clr_cnt_q     <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
      busy          <= 1'b0;
      inc_q         <= 1'b0;
      wr_q          <= 1'b0;
      inc_pending_q <= 1'b0;
      clr_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      clr_cnt_q     <= clr_cnt_d;
      mem_addr      <= mem_addr_d;
      mem_wdata     <= mem_wdata_d;
      mem_we        <= mem_we_d;
      busy          <= busy_d;
      inc_q         <= inc_btn;
      wr_q          <= wr_btn;
      inc_pending_q <= inc_pending_d;
      clr_pending_q <= clr_pending_d;
    end
  end

  // Address pipeline matching the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        disp_pipe_q[i] <= '0;
      end
    end else begin
      disp_pipe_q[0] <= mem_addr;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        disp_pipe_q[i] <= disp_pipe_q[i-1];
      end
    end
  end

  assign disp_addr = disp_pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_bram_seq_ctrl.sv
// Self-checking bench for bram_seq_ctrl: vector table, write scoreboard and a BRAM model.
module tb_bram_seq_ctrl;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inc_btn = 1'b0;
  logic          wr_btn = 1'b0;
  logic          clr_req = 1'b0;
  logic          scan_en = 1'b0;
  logic [DW-1:0] data_sw = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [AW-1:0] disp_addr;
  logic          busy;

  bram_seq_ctrl #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .SCAN_DIV (4),
    .RD_LAT   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inc_btn   (inc_btn),
    .wr_btn    (wr_btn),
    .clr_req   (clr_req),
    .scan_en   (scan_en),
    .data_sw   (data_sw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .disp_addr (disp_addr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int            n_inc;
    logic          wr;
    logic [DW-1:0] data;
    int            hold;
    logic [AW-1:0] exp_addr;
  } vec_t;

  int            n_chk = 0;
  int            n_fail = 0;
  wr_t           exp_q[$];
  logic [DW-1:0] mem [32];
  logic          rst_seen;
  logic [AW-1:0] prev_addr;
  vec_t          vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM model and reset tracker
  always @(posedge clk) begin
    rst_seen <= rst;
    if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
  end

  // Monitor: display-address lag and write scoreboard
  always @(negedge clk) begin
    wr_t e;
    if (rst_seen === 1'b0) begin
      chk("disp_lag", 32'(disp_addr), 32'(prev_addr));
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required no write at %0t",
                   mem_addr, mem_wdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 32'(mem_addr), 32'(e.addr));
          chk("write_data", 32'(mem_wdata), 32'(e.data));
        end
      end
    end
    prev_addr = mem_addr;
  end

  task automatic pulse_inc();
    inc_btn = 1'b1;
    @(negedge clk);
    inc_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_wr(input logic [DW-1:0] d, input int hold, input logic [AW-1:0] a);
    exp_q.push_back('{addr: a, data: d});
    data_sw = d;
    wr_btn  = 1'b1;
    repeat (hold) @(negedge clk);
    wr_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v);
    repeat (v.n_inc) pulse_inc();
    if (v.wr) pulse_wr(v.data, v.hold, v.exp_addr);
    repeat (3) @(negedge clk);
    chk("vec_addr", 32'(mem_addr), 32'(v.exp_addr));
    chk("vec_we_idle", 32'(mem_we), 32'd0);
  endtask

  task automatic clear_pulse();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int i = 0; i < 5 && busy !== 1'b1; i++) @(negedge clk);
    chk("busy_start", 32'(busy), 32'd1);
  endtask

  initial begin
    int cnt;
    logic [AW-1:0] a;

    vecs[0] = '{n_inc: 3,  wr: 1'b1, data: 8'hA5, hold: 20, exp_addr: 5'd3};
    vecs[1] = '{n_inc: 4,  wr: 1'b0, data: 8'h00, hold: 0,  exp_addr: 5'd7};
    vecs[2] = '{n_inc: 22, wr: 1'b0, data: 8'h00, hold: 0,  exp_addr: 5'd30};
    vecs[3] = '{n_inc: 1,  wr: 1'b0, data: 8'h00, hold: 0,  exp_addr: 5'd31};
    vecs[4] = '{n_inc: 1,  wr: 1'b0, data: 8'h00, hold: 0,  exp_addr: 5'd0};
    vecs[5] = '{n_inc: 1,  wr: 1'b1, data: 8'h81, hold: 2,  exp_addr: 5'd1};
    vecs[6] = '{n_inc: 8,  wr: 1'b0, data: 8'h00, hold: 0,  exp_addr: 5'd9};
    for (int i = 0; i < 32; i++) mem[i] = 8'hEE;

    // Reset and hold
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_disp", 32'(disp_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_we", 32'(mem_we), 32'd0);
    end

    // Manual steps and the held-button write
    for (int i = 0; i < 2; i++) apply_vec(vecs[i]);

    // Coincident write and increment at address 7
    exp_q.push_back('{addr: 5'd7, data: 8'h3C});
    data_sw = 8'h3C;
    inc_btn = 1'b1;
    wr_btn  = 1'b1;
    @(negedge clk);
    chk("coinc_we", 32'(mem_we), 32'd1);
    chk("coinc_addr", 32'(mem_addr), 32'd7);
    chk("coinc_data", 32'(mem_wdata), 32'h3C);
    inc_btn = 1'b0;
    wr_btn  = 1'b0;
    @(negedge clk);
    chk("coinc_we_off", 32'(mem_we), 32'd0);
    chk("coinc_addr_hold", 32'(mem_addr), 32'd7);
    @(negedge clk);
    chk("coinc_addr_inc", 32'(mem_addr), 32'd8);

    // Wrap 30 -> 31 -> 0 -> 1, then step to 9
    for (int i = 2; i < 7; i++) apply_vec(vecs[i]);

    // Full clear from address 9 with an inc edge mid-sweep
    for (int i = 0; i < 32; i++) exp_q.push_back('{addr: AW'(i), data: 8'h00});
    clear_pulse();
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      chk("clear_addr", 32'(mem_addr), 32'(cnt[AW-1:0]));
      chk("clear_we", 32'(mem_we), 32'd1);
      cnt++;
      if (cnt == 10) inc_btn = 1'b1;
      if (cnt == 11) inc_btn = 1'b0;
      @(negedge clk);
    end
    chk("clear_len", 32'(cnt), 32'd32);
    chk("clear_end_addr", 32'(mem_addr), 32'd0);
    repeat (3) @(negedge clk);
    chk("clear_inc_dropped", 32'(mem_addr), 32'd0);
    for (int i = 0; i < 32; i++) chk("clear_mem", 32'(mem[i]), 32'd0);

    // Auto-scan every 4 cycles; manual inc on a tick cycle merges into one step
    scan_en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk("scan_addr", 32'(mem_addr), 32'(k / 4));
      if (k == 19) inc_btn = 1'b1;
      if (k == 20) inc_btn = 1'b0;
    end
    scan_en = 1'b0;
    repeat (8) @(negedge clk);
    chk("scan_off_addr", 32'(mem_addr), 32'd6);

    // Fill every address with a known nonzero pattern
    for (int i = 0; i < 32; i++) begin
      a = AW'(6 + i);
      pulse_wr(8'h80 | DW'(a), 1, a);
      pulse_inc();
    end
    chk("fill_addr", 32'(mem_addr), 32'd6);

    // Reset while the clear is about to write address 12
    for (int i = 0; i < 12; i++) exp_q.push_back('{addr: AW'(i), data: 8'h00});
    clear_pulse();
    for (int i = 0; i < 40 && mem_addr !== 5'd11; i++) @(negedge clk);
    chk("reach_addr11", 32'(mem_addr), 32'd11);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_wdata", 32'(mem_wdata), 32'd0);
    chk("abort_disp", 32'(disp_addr), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_idle_we", 32'(mem_we), 32'd0);
      chk("abort_idle_busy", 32'(busy), 32'd0);
    end
    for (int i = 0; i < 32; i++) begin
      if (i < 12) chk("partial_clr_mem", 32'(mem[i]), 32'd0);
      else        chk("partial_keep_mem", 32'(mem[i]), 32'(8'h80 | 8'(i)));
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before %0t", $time);
    $fatal(1);
  end

endmodule
